commit_trace_checker: RTL and testbench
=======================================

Name: commit_trace_checker

Overview:
- Synthesizable in-system checker. Compares the processor's architectural commit stream against a golden expected-commit stream, in order.
- Commit stream: register write, load and store events from the memory/writeback boundary.
- Golden stream: supplied by a valid/ready producer, either a testbench replaying a golden ptrace or a preloaded ROM.
- Sits beside proc_hier. DUT commits are buffered in a FIFO and checked against golden records, one per cycle. The block reports pass/fail, an error code and the failing commit index.

Parameters:
DEPTH, 8, DUT commit FIFO entries (power of 2, >=2)
TIMEOUT, 1024, max cycles in DRAIN waiting for golden records before fail

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
c_regwrt  in  1  DUT register write this cycle
c_wreg  in  3  DUT destination register
c_wdata  in  16  DUT register write data
c_memrd  in  1  DUT load this cycle
c_memwr  in  1  DUT store this cycle
c_addr  in  16  DUT memory address
c_mdata  in  16  DUT load data (memrd) or store data (memwr)
c_halt  in  1  DUT halt reached
exp_valid  in  1  golden record valid
exp_ready  out  1  golden record consumed this cycle
exp_rec  in  54  golden record {regwrt, wreg[2:0], wdata[15:0], memrd, memwr, addr[15:0], mdata[15:0]}
exp_last  in  1  current golden record is the final one
done  out  1  check finished (pass or fail)
pass  out  1  finished with no error
err_code  out  2  0 none, 1 data mismatch, 2 FIFO overflow, 3 length mismatch/timeout
commit_count  out  32  commits compared successfully
fail_index  out  32  commit_count value at first failure

Behaviour:
- Reset (async, rst=1): state RUN, FIFO empty. All outputs 0: done, pass, err_code, commit_count, fail_index, exp_ready.
- Commit event = c_regwrt | c_memrd | c_memwr. c_memrd & c_memwr together = FAIL, err 1.
- Push: in RUN, at the posedge where a commit event is present, pack the inputs in exp_rec format and push. No pushes outside RUN.
- Compare/pop (combinational): exp_ready = (state RUN or DRAIN) & FIFO not empty & exp_valid. On that posedge, pop the head and consume the golden record.
- Match rule, applied per consumed pair:
  - regwrt bits must be equal; if both 1, wreg and wdata must be equal.
  - memrd and memwr bits must each be equal; if either is 1, addr and mdata must be equal.
  - Fields not covered above are don't-care.
- On match: commit_count increments by 1 at the same posedge, saturating at 2^32-1.
- On mismatch: next state FAIL, err_code=1, fail_index=commit_count at the same edge. commit_count is not incremented.
- Simultaneous push and pop with FIFO full: legal, occupancy unchanged.
- Overflow: push while full with no pop -> FAIL, err 2.
- Consumed golden record with exp_last=1 and a match: set last_seen.
- Length errors:
  - Commit event arriving with last_seen=1 -> FAIL, err 3.
  - exp_valid with last_seen=1 is ignored; exp_ready stays 0.
- RUN + c_halt -> DRAIN. A commit on the halt cycle is still pushed. The timeout counter resets to 0.
- DRAIN:
  - Continue popping and comparing.
  - Timeout counter increments on every cycle the FIFO is non-empty and exp_valid=0; it resets on each pop.
  - Counter reaching TIMEOUT -> FAIL, err 3.
  - FIFO empty and last_seen=1 -> PASS.
  - FIFO empty and last_seen=0 -> FAIL, err 3.
- PASS: done=1, pass=1. FAIL: done=1, pass=0. Both are terminal until rst.
- Error priority when several hit the same cycle: 1 > 2 > 3.
- All outputs are registered except exp_ready.
- rst mid-operation clears FIFO, counters, last_seen and state immediately.

Test Plan:
- Basic pass:
  - Stimulus: 3 DUT commits (R1=0x0005; STORE 0x0010=0x1234; LOAD 0x0010=0x1234) with matching golden records, last on the 3rd, then c_halt.
  - Response: done=1, pass=1, commit_count=3, err_code=0.
- Data mismatch:
  - Stimulus: golden 2nd record wdata=0x00FF vs DUT 0x00FE.
  - Response: done=1, pass=0, err_code=1, fail_index=1, commit_count=1.
- Backpressure and overflow:
  - Stimulus: exp_valid=0 while DEPTH commits are pushed, then one more.
  - Response: err_code=2. A separate run that releases exp_valid before the DEPTH+1th commit passes with 9 commits.
- Full with simultaneous push/pop:
  - Stimulus: FIFO at DEPTH, commit and pop in the same cycle, repeated 20 cycles.
  - Response: no overflow, commit_count=20.
- Length mismatch, two runs:
  - Golden stream ends (exp_last) after 2 records while the DUT commits 3: err_code=3 at the 3rd commit.
  - DUT halts after 2 commits, golden has 3, exp_valid then held 0: err_code=3 after TIMEOUT cycles.
- Async reset mid-DRAIN:
  - Stimulus: assert rst for a half-cycle.
  - Response: done=0, commit_count=0, exp_ready=0 immediately. A subsequent clean run passes.

Source files
------------

// File: rtl/commit_trace_checker.sv
// commit_trace_checker: buffers DUT commits and compares them, in order,
// against a golden valid/ready record stream; reports pass/fail and where.
module commit_trace_checker #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_regwrt,
    input  logic [2:0]  c_wreg,
    input  logic [15:0] c_wdata,
    input  logic        c_memrd,
    input  logic        c_memwr,
    input  logic [15:0] c_addr,
    input  logic [15:0] c_mdata,
    input  logic        c_halt,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [53:0] exp_rec,
    input  logic        exp_last,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] commit_count,
    output logic [31:0] fail_index
);
    // state | meaning
    // RUN   | accepting DUT commits, comparing against golden records
    // DRAIN | halt seen; comparing whatever is still buffered
    // PASS  | every commit matched and the golden stream ended with them
    // FAIL  | error latched in err_code/fail_index; held until reset
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, PASS = 2'd2, FAIL = 2'd3} stateT;

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_COUNT    = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_COUNT = TW'(TIMEOUT);

    stateT         state, nextState;
    logic [53:0]   fifoMem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   fifoCount;
    logic          lastSeen;
    logic [TW-1:0] tmoCount;

    logic        commitEv, inRun, inDrain, fifoEmpty, fifoFull;
    logic        push, pop, doPush, headMatch;
    logic        errData, errOvf, errLen;
    logic [1:0]  errSel;
    logic [53:0] commitRec;

    // Field-wise compare; fields not qualified by their event bits are ignored.
    function automatic logic recMatch(input logic [53:0] a, input logic [53:0] b);
        logic ok;
        ok = (a[53] == b[53]) && (a[33:32] == b[33:32]);
        if (a[53] && b[53])
            ok = ok && (a[52:34] == b[52:34]);
        if (a[33] || a[32] || b[33] || b[32])
            ok = ok && (a[31:0] == b[31:0]);
        return ok;
    endfunction

    assign commitEv  = c_regwrt | c_memrd | c_memwr;
    assign commitRec = {c_regwrt, c_wreg, c_wdata, c_memrd, c_memwr, c_addr, c_mdata};
    assign inRun     = (state == RUN);
    assign inDrain   = (state == DRAIN);
    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == FULL_COUNT);
    assign push      = inRun && commitEv;
    // A golden record arriving after the final one is never consumed.
    assign exp_ready = (inRun || inDrain) && !fifoEmpty && exp_valid && !lastSeen;
    assign pop       = exp_ready;
    // Push into a full FIFO is fine when the head leaves on the same edge.
    assign doPush    = push && (!fifoFull || pop);
    assign headMatch = recMatch(fifoMem[rdPtr], exp_rec);

    // Error detection with priority data > overflow > length, and next state.
    always_comb begin
        nextState = state;
        errSel    = 2'd0;
        errData   = (pop && !headMatch) || (inRun && c_memrd && c_memwr);
        errOvf    = push && fifoFull && !pop;
        errLen    = (push && lastSeen)
                 || (inDrain && (tmoCount == TIMEOUT_COUNT))
                 || (inDrain && fifoEmpty && !lastSeen);
        if (errData)
            errSel = 2'd1;
        else if (errOvf)
            errSel = 2'd2;
        else if (errLen)
            errSel = 2'd3;

        if (errSel != 2'd0)
            nextState = FAIL;
        else if (inDrain && fifoEmpty && lastSeen)
            nextState = PASS;
        else if (inRun && c_halt)
            nextState = DRAIN;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= nextState;
    end

    // Commit FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (doPush)
            fifoMem[wrPtr] <= commitRec;
    end

    // Pointers, counters, golden-end tracking and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            fifoCount    <= '0;
            lastSeen     <= 1'b0;
            tmoCount     <= '0;
            commit_count <= '0;
            fail_index   <= '0;
            err_code     <= 2'd0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + AW'(1);
            if (pop)
                rdPtr <= rdPtr + AW'(1);
            case ({doPush, pop})
                2'b10:   fifoCount <= fifoCount + (AW + 1)'(1);
                2'b01:   fifoCount <= fifoCount - (AW + 1)'(1);
                default: ;
            endcase

            if (pop && headMatch) begin
                if (commit_count != '1)
                    commit_count <= commit_count + 32'd1;
                if (exp_last)
                    lastSeen <= 1'b1;
            end

            // Counts cycles where buffered commits wait without a golden record.
            if (inRun)
                tmoCount <= '0;
            else if (inDrain) begin
                if (pop)
                    tmoCount <= '0;
                else if (!fifoEmpty)
                    tmoCount <= tmoCount + TW'(1);
            end

            if ((nextState == FAIL) && (state != FAIL)) begin
                err_code   <= errSel;
                fail_index <= commit_count;
            end
            done <= (nextState == PASS) || (nextState == FAIL);
            pass <= (nextState == PASS);
        end
    end
endmodule

// File: tb/tb_commit_trace_checker.sv
// tb_commit_trace_checker: directed runs with a golden-record producer and a
// scoreboard of expected commit_count values checked at every consumed pair.
module tb_commit_trace_checker;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_regwrt, c_memrd, c_memwr, c_halt;
    logic [2:0]  c_wreg;
    logic [15:0] c_wdata, c_addr, c_mdata;
    logic        exp_valid, exp_ready, exp_last;
    logic [53:0] exp_rec;
    logic        done, pass;
    logic [1:0]  err_code;
    logic [31:0] commit_count, fail_index;

    typedef struct packed {
        logic [53:0] rec;
        logic        last;
    } goldT;

    goldT        goldQ[$];
    logic [31:0] sbQ[$];
    logic        goldEn;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    commit_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .c_regwrt(c_regwrt), .c_wreg(c_wreg), .c_wdata(c_wdata),
        .c_memrd(c_memrd), .c_memwr(c_memwr), .c_addr(c_addr), .c_mdata(c_mdata),
        .c_halt(c_halt),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_rec(exp_rec), .exp_last(exp_last),
        .done(done), .pass(pass), .err_code(err_code),
        .commit_count(commit_count), .fail_index(fail_index)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [53:0] regRec(input logic [2:0] r, input logic [15:0] d);
        return {1'b1, r, d, 1'b0, 1'b0, 16'h0000, 16'h0000};
    endfunction

    function automatic logic [53:0] storeRec(input logic [15:0] a, input logic [15:0] d);
        return {1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, a, d};
    endfunction

    function automatic logic [53:0] loadRec(input logic [15:0] a, input logic [15:0] d);
        return {1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, a, d};
    endfunction

    task automatic clearCommit();
        c_regwrt = 1'b0; c_wreg = 3'd0; c_wdata = 16'h0;
        c_memrd = 1'b0; c_memwr = 1'b0; c_addr = 16'h0; c_mdata = 16'h0;
        c_halt = 1'b0;
    endtask

    task automatic driveCommit(input logic [53:0] r);
        c_regwrt = r[53]; c_wreg = r[52:50]; c_wdata = r[49:34];
        c_memrd = r[33]; c_memwr = r[32]; c_addr = r[31:16]; c_mdata = r[15:0];
    endtask

    task automatic addGold(input logic [53:0] r, input logic last);
        goldT g;
        g.rec  = r;
        g.last = last;
        goldQ.push_back(g);
    endtask

    task automatic clearBench();
        clearCommit();
        exp_valid = 1'b0; exp_rec = '0; exp_last = 1'b0;
        goldEn = 1'b1;
        goldQ.delete();
        sbQ.delete();
    endtask

    // One clock: present the golden head, sample exp_ready before the edge,
    // then score any consumed pair against the next expected commit_count.
    task automatic tick();
        logic sawReady;
        if (goldEn && goldQ.size() > 0) begin
            exp_valid = 1'b1; exp_rec = goldQ[0].rec; exp_last = goldQ[0].last;
        end else begin
            exp_valid = 1'b0; exp_rec = '0; exp_last = 1'b0;
        end
        #1 sawReady = exp_ready;
        @(posedge clk);
        #1;
        if (sawReady) begin
            void'(goldQ.pop_front());
            if (sbQ.size() > 0)
                check("sb_count", commit_count, sbQ.pop_front());
            else
                check("sb_extra_pop", 32'(sbQ.size()), 32'd1);
        end
        clearCommit();
        @(negedge clk);
    endtask

    task automatic commitTick(input logic [53:0] r, input logic [31:0] expCount);
        driveCommit(r);
        sbQ.push_back(expCount);
        tick();
    endtask

    task automatic doReset();
        clearBench();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic runBasic();
        addGold(regRec(3'd1, 16'h0005), 1'b0);
        addGold(storeRec(16'h0010, 16'h1234), 1'b0);
        addGold(loadRec(16'h0010, 16'h1234), 1'b1);
        commitTick(regRec(3'd1, 16'h0005), 32'd1);
        commitTick(storeRec(16'h0010, 16'h1234), 32'd2);
        commitTick(loadRec(16'h0010, 16'h1234), 32'd3);
        c_halt = 1'b1;
        tick();
        waitDone("basic_done", 20);
        check("basic_pass", 32'(pass), 32'd1);
        check("basic_count", commit_count, 32'd3);
        check("basic_err", 32'(err_code), 32'd0);
        check("basic_sb_left", 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clearBench();

        // Reset state, with a golden record offered to an empty FIFO.
        doReset();
        exp_valid = 1'b1; exp_rec = regRec(3'd2, 16'h0001); exp_last = 1'b0;
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_code), 32'd0);
        check("rst_count", commit_count, 32'd0);
        check("rst_fidx", fail_index, 32'd0);
        check("rst_ready", 32'(exp_ready), 32'd0);
        @(negedge clk);

        // Basic pass.
        doReset();
        runBasic();

        // Data mismatch on the second record.
        doReset();
        addGold(regRec(3'd1, 16'h0005), 1'b0);
        addGold(regRec(3'd2, 16'h00FF), 1'b0);
        addGold(regRec(3'd3, 16'h0007), 1'b1);
        commitTick(regRec(3'd1, 16'h0005), 32'd1);
        commitTick(regRec(3'd2, 16'h00FE), 32'd1);
        driveCommit(regRec(3'd3, 16'h0007));
        tick();
        waitDone("mm_done", 10);
        check("mm_pass", 32'(pass), 32'd0);
        check("mm_err", 32'(err_code), 32'd1);
        check("mm_fidx", fail_index, 32'd1);
        check("mm_count", commit_count, 32'd1);

        // Overflow: DEPTH commits fit, the next one without a pop does not.
        doReset();
        goldEn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            driveCommit(regRec(3'(i), 16'(i + 100)));
            tick();
        end
        check("ovf_not_yet", 32'(done), 32'd0);
        driveCommit(regRec(3'd0, 16'h0999));
        tick();
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_err", 32'(err_code), 32'd2);
        check("ovf_pass", 32'(pass), 32'd0);

        // Backpressure released on the DEPTH+1th commit.
        doReset();
        goldEn = 1'b0;
        for (int i = 0; i <= DEPTH; i++)
            addGold(regRec(3'(i), 16'(i + 200)), i == DEPTH);
        for (int i = 0; i < DEPTH; i++)
            commitTick(regRec(3'(i), 16'(i + 200)), 32'(i + 1));
        goldEn = 1'b1;
        commitTick(regRec(3'(DEPTH), 16'(DEPTH + 200)), 32'(DEPTH + 1));
        check("bp_no_ovf", 32'(done), 32'd0);
        c_halt = 1'b1;
        tick();
        waitDone("bp_done", 40);
        check("bp_pass", 32'(pass), 32'd1);
        check("bp_count", commit_count, 32'(DEPTH + 1));
        check("bp_sb_left", 32'(sbQ.size()), 32'd0);

        // Full FIFO with simultaneous push and pop for 20 cycles.
        doReset();
        goldEn = 1'b0;
        for (int i = 0; i < DEPTH + 20; i++)
            addGold(regRec(3'(i), 16'(i * 7 + 3)), i == DEPTH + 19);
        for (int i = 0; i < DEPTH; i++)
            commitTick(regRec(3'(i), 16'(i * 7 + 3)), 32'(i + 1));
        goldEn = 1'b1;
        for (int i = DEPTH; i < DEPTH + 20; i++)
            commitTick(regRec(3'(i), 16'(i * 7 + 3)), 32'(i + 1));
        check("full_count", commit_count, 32'd20);
        check("full_no_done", 32'(done), 32'd0);
        check("full_err", 32'(err_code), 32'd0);
        c_halt = 1'b1;
        tick();
        waitDone("full_done", 40);
        check("full_pass", 32'(pass), 32'd1);
        check("full_final_count", commit_count, 32'(DEPTH + 20));

        // Golden stream ends after 2 records, DUT commits a third.
        doReset();
        addGold(regRec(3'd4, 16'h0A0A), 1'b0);
        addGold(storeRec(16'h0020, 16'h5555), 1'b1);
        commitTick(regRec(3'd4, 16'h0A0A), 32'd1);
        commitTick(storeRec(16'h0020, 16'h5555), 32'd2);
        tick();
        check("len_a_not_yet", 32'(done), 32'd0);
        driveCommit(loadRec(16'h0020, 16'h5555));
        tick();
        check("len_a_done", 32'(done), 32'd1);
        check("len_a_err", 32'(err_code), 32'd3);
        check("len_a_count", commit_count, 32'd2);

        // DUT halts after 2 commits, golden withheld: timeout.
        doReset();
        goldEn = 1'b0;
        addGold(regRec(3'd1, 16'h0011), 1'b0);
        addGold(regRec(3'd2, 16'h0022), 1'b0);
        addGold(regRec(3'd3, 16'h0033), 1'b1);
        driveCommit(regRec(3'd1, 16'h0011));
        tick();
        driveCommit(regRec(3'd2, 16'h0022));
        tick();
        c_halt = 1'b1;
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++)
            tick();
        check("tmo_early", 32'(done), 32'd0);
        waitDone("tmo_done", 5);
        check("tmo_err", 32'(err_code), 32'd3);
        check("tmo_count", commit_count, 32'd0);

        // Async reset in the middle of DRAIN.
        doReset();
        goldEn = 1'b0;
        addGold(regRec(3'd5, 16'h0505), 1'b0);
        addGold(regRec(3'd6, 16'h0606), 1'b0);
        addGold(regRec(3'd7, 16'h0707), 1'b1);
        commitTick(regRec(3'd5, 16'h0505), 32'd1);
        driveCommit(regRec(3'd6, 16'h0606));
        tick();
        driveCommit(regRec(3'd7, 16'h0707));
        tick();
        c_halt = 1'b1;
        tick();
        goldEn = 1'b1;
        tick();
        goldEn = 1'b0;
        tick();
        tick();
        exp_valid = 1'b1; exp_rec = goldQ[0].rec; exp_last = goldQ[0].last;
        #1;
        check("pre_rst_ready", 32'(exp_ready), 32'd1);
        check("pre_rst_count", commit_count, 32'd1);
        check("pre_rst_done", 32'(done), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_count", commit_count, 32'd0);
        check("mid_rst_ready", 32'(exp_ready), 32'd0);
        #4 rst = 1'b0;
        clearBench();
        @(negedge clk);
        runBasic();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
